pcpi_rr_arbiter: RTL and testbench
==================================

Name: pcpi_rr_arbiter

Overview:
- Shares one PCPI coprocessor (the fused matrix-multiply unit) between NUM_REQ independent requesters, e.g. the nibble-serial host loader and an on-chip instruction sequencer.
- Round-robin arbitration; one transaction in flight at a time.
- Drives the coprocessor's PCPI-side valid/insn and returns ready/wr/rd to the winning requester as a registered one-cycle response.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- INSN_W, 32, instruction width.
- DATA_W, 32, result width.
- TIMEOUT_CYC, 16, watchdog limit in cycles; used only with PCPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's req_ready.
- req_insn  in  NUM_REQ*INSN_W  packed instructions; requester i occupies bits [i*INSN_W +: INSN_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle completion pulse.
- req_wr  out  1  coprocessor write flag, valid while any req_ready bit is high.
- req_rd  out  DATA_W  result, valid while any req_ready bit is high.
- req_err  out  1  timeout abort flag, valid with req_ready; always 0 without the macro.
- grant  out  NUM_REQ  one-hot owner of the current transaction; 0 in IDLE.
- busy  out  1  high in BUSY or RESP.
- co_valid  out  1  to coprocessor pcpi_valid.
- co_insn  out  INSN_W  to coprocessor pcpi_insn.
- co_ready  in  1  from coprocessor pcpi_ready.
- co_wr  in  1  from coprocessor pcpi_wr.
- co_wait  in  1  from coprocessor pcpi_wait.
- co_rd  in  DATA_W  from coprocessor pcpi_rd.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; all outputs 0.
  - last_idx=NUM_REQ-1, so requester 0 wins first after reset.
- Reset mid-transaction: co_valid drops immediately; the transaction is lost and no req_ready is issued.
- IDLE:
  - If any req_valid bit is set, choose the first set bit scanning from (last_idx+1) mod NUM_REQ upward, with wrap-around.
  - Register: idx, grant=1<<idx, co_insn=req_insn[idx], co_valid=1; go to BUSY.
  - Insn is latched at the grant edge; later changes to req_insn are ignored.
- BUSY:
  - co_valid is held high and co_insn is stable.
  - On sampling co_ready=1: latch co_wr and co_rd, clear co_valid, go to RESP.
  - Simultaneous co_ready and timeout expiry: co_ready wins.
- RESP (exactly one cycle):
  - req_ready[idx]=1; req_wr, req_rd, req_err driven from latches.
  - Next edge: last_idx=idx, grant=0, go to IDLE.
  - Requester must drop req_valid on the edge at which it samples req_ready. A requester still high in IDLE is treated as a new request.
- A requester dropping req_valid after being granted does not abort the transaction; the response pulse is still issued.
- Latency: req_valid sampled at edge 0 gives co_valid high in cycle 1. co_ready sampled at edge k gives req_ready in cycle k+1. IDLE is re-entered at k+2, so the minimum inter-grant gap is 1 IDLE cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
- req_rd and req_wr hold their last values outside RESP. Benches must check them only with req_ready.

Optional Feature:
- Macro: PCPI_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to BUSY and on any cycle with co_wait=1; otherwise it increments.
  - If the counter reaches TIMEOUT_CYC in BUSY with co_ready=0: clear co_valid, go to RESP with req_err=1, req_wr=0, req_rd=0.
- Without the macro: no counter; BUSY waits indefinitely; req_err is tied 0.

Decomposition:
- Package pcpi_arb_pkg:
  - state enum (IDLE=2'b00, BUSY=2'b01, RESP=2'b10).
  - default INSN_W/DATA_W constants.
  - clog2-based IDX_W.
- Sub-module rr_pick: combinational, inputs req vector and last_idx; outputs the winner index and a found flag. Reusable by other arbiters.

Test Plan:
- Single request:
  - Stimulus: req_valid=2'b01, insn 32'h0200_000B; coprocessor returns ready 3 cycles after co_valid with wr=1, rd=32'hDEAD_BEEF.
  - Expect: co_insn=32'h0200_000B; req_ready=2'b01 for exactly 1 cycle with req_rd=32'hDEAD_BEEF, req_wr=1; grant=0 afterwards.
- Contention:
  - Stimulus: both requesters valid continuously for 4 transactions.
  - Expect: grant sequence 01,10,01,10; each req_ready is one-hot and matches grant.
- Late insn change: requester 1 alters req_insn to 32'h1234_5678 while BUSY → co_insn stays at the latched value.
- Reset mid-BUSY: assert rst_n low asynchronously between edges → co_valid, grant and busy go to 0 immediately; no req_ready; the next grant goes to requester 0.
- Timeout:
  - With PCPI_ARB_TIMEOUT_EN and co_wait=0, co_ready never asserted → req_ready and req_err=1 at BUSY cycle 17 (TIMEOUT_CYC=16).
  - With co_wait=1 held → no timeout after 100 cycles.
- Coincidence: co_ready asserted in the same cycle the timeout count would expire → normal response, req_err=0.

Source files
------------

// File: rtl/pcpi_arb_pkg.sv
// Shared types and constants for the PCPI round-robin arbiter and its picker.
package pcpi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int unsigned DEF_INSN_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MAX_REQ    = 8;
  // Index width sized for the largest supported requester count.
  localparam int unsigned IDX_W      = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit after last_idx, wrapping.
module rr_pick
  import pcpi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Two ascending passes: indices above last_idx first, then the wrapped-around part.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (i > int'(last_idx))) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (i <= int'(last_idx))) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcpi_rr_arbiter.sv
// Round-robin sharing of one PCPI coprocessor between NUM_REQ requesters.
// Optional watchdog abort enabled by defining PCPI_ARB_TIMEOUT_EN.
module pcpi_rr_arbiter
  import pcpi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned INSN_W      = DEF_INSN_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*INSN_W-1:0] req_insn,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      req_wr,
  output logic [DATA_W-1:0]         req_rd,
  output logic                      req_err,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      co_valid,
  output logic [INSN_W-1:0]         co_insn,
  input  logic                      co_ready,
  input  logic                      co_wr,
  input  logic                      co_wait,
  input  logic [DATA_W-1:0]         co_rd
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, last_q, last_d;
  logic [IDX_W-1:0]    pick_idx_c;
  logic                pick_found_c;
  logic [NUM_REQ-1:0]  grant_d, req_ready_d;
  logic                co_valid_d, req_wr_d, busy_d;
  logic [INSN_W-1:0]   co_insn_d;
  logic [DATA_W-1:0]   req_rd_d;
  logic                expire_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (req_valid),
    .last_idx (last_q),
    .idx      (pick_idx_c),
    .found    (pick_found_c)
  );

`ifdef PCPI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_d;

  // Expiry means this cycle's increment would bring the count to TIMEOUT_CYC.
  assign expire_c = (state_q == ST_BUSY) && !co_ready && !co_wait &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      req_err <= 1'b0;
    end else begin
      req_err <= err_d;
      if ((state_q != ST_BUSY) || co_wait) cnt_q <= '0;
      else                                  cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = co_wait ^ (TIMEOUT_CYC == 0);
  assign expire_c  = 1'b0;
  assign req_err   = 1'b0;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      grant     <= '0;
      req_ready <= '0;
      req_wr    <= 1'b0;
      req_rd    <= '0;
      busy      <= 1'b0;
      co_valid  <= 1'b0;
      co_insn   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      grant     <= grant_d;
      req_ready <= req_ready_d;
      req_wr    <= req_wr_d;
      req_rd    <= req_rd_d;
      busy      <= busy_d;
      co_valid  <= co_valid_d;
      co_insn   <= co_insn_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    grant_d     = grant;
    req_ready_d = '0;
    req_wr_d    = req_wr;
    req_rd_d    = req_rd;
    co_valid_d  = co_valid;
    co_insn_d   = co_insn;
`ifdef PCPI_ARB_TIMEOUT_EN
    err_d       = req_err;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          idx_d      = pick_idx_c;
          grant_d    = NUM_REQ'(1) << pick_idx_c;
          co_insn_d  = req_insn[int'(pick_idx_c)*INSN_W +: INSN_W];
          co_valid_d = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (co_ready) begin
          req_wr_d    = co_wr;
          req_rd_d    = co_rd;
          co_valid_d  = 1'b0;
          req_ready_d = grant;
          state_d     = ST_RESP;
`ifdef PCPI_ARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end else if (expire_c) begin
          req_wr_d    = 1'b0;
          req_rd_d    = '0;
          co_valid_d  = 1'b0;
          req_ready_d = grant;
          state_d     = ST_RESP;
`ifdef PCPI_ARB_TIMEOUT_EN
          err_d       = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        last_d  = idx_q;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d    = '0;
        co_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_pcpi_rr_arbiter.sv
// Directed self-checking bench for pcpi_rr_arbiter; timeout steps run when PCPI_ARB_TIMEOUT_EN is defined.
module tb_pcpi_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_insn;
  logic [1:0]  req_ready;
  logic        req_wr;
  logic [31:0] req_rd;
  logic        req_err;
  logic [1:0]  grant;
  logic        busy;
  logic        co_valid;
  logic [31:0] co_insn;
  logic        co_ready;
  logic        co_wr;
  logic        co_wait;
  logic [31:0] co_rd;

  int n_cmp = 0;
  int n_err = 0;

  pcpi_rr_arbiter #(.NUM_REQ(2), .INSN_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_insn  (req_insn),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_rd    (req_rd),
    .req_err   (req_err),
    .grant     (grant),
    .busy      (busy),
    .co_valid  (co_valid),
    .co_insn   (co_insn),
    .co_ready  (co_ready),
    .co_wr     (co_wr),
    .co_wait   (co_wait),
    .co_rd     (co_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_g [4];
  logic [31:0] exp_rd;
  logic        seen;

  initial begin
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    rst_n = 1'b0; req_valid = '0; req_insn = '0;
    co_ready = 1'b0; co_wr = 1'b0; co_wait = 1'b0; co_rd = '0;
    #12;
    chk("rst_co_valid", 32'(co_valid), 32'd0);
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_ready",    32'(req_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single request from requester 0, coprocessor answers in the third BUSY cycle.
    req_valid = 2'b01;
    req_insn[31:0] = 32'h0200_000B;
    step();
    chk("t1_co_valid", 32'(co_valid), 32'd1);
    chk("t1_co_insn",  co_insn,       32'h0200_000B);
    chk("t1_grant",    32'(grant),    32'd1);
    chk("t1_busy",     32'(busy),     32'd1);
    step();
    chk("t1_wait_ready", 32'(req_ready), 32'd0);
    step();
    co_ready = 1'b1; co_wr = 1'b1; co_rd = 32'hDEAD_BEEF;
    step();
    co_ready = 1'b0; co_wr = 1'b0; co_rd = '0;
    chk("t1_ready",    32'(req_ready), 32'd1);
    chk("t1_rd",       req_rd,         32'hDEAD_BEEF);
    chk("t1_wr",       32'(req_wr),    32'd1);
    chk("t1_err",      32'(req_err),   32'd0);
    chk("t1_co_drop",  32'(co_valid),  32'd0);
    req_valid = 2'b00;
    step();
    chk("t1_ready_1cyc", 32'(req_ready), 32'd0);
    chk("t1_grant_idle", 32'(grant),     32'd0);
    chk("t1_busy_idle",  32'(busy),      32'd0);

    // Requester 1: insn latched at grant, later change and early req drop ignored.
    req_valid = 2'b10;
    req_insn[63:32] = 32'hCAFE_0001;
    step();
    chk("t2_grant",   32'(grant), 32'd2);
    chk("t2_co_insn", co_insn,    32'hCAFE_0001);
    req_insn[63:32] = 32'h1234_5678;
    req_valid = 2'b00;
    step();
    chk("t2_insn_stable", co_insn,        32'hCAFE_0001);
    chk("t2_co_valid",    32'(co_valid),  32'd1);
    co_ready = 1'b1; co_wr = 1'b0; co_rd = 32'h5555_AAAA;
    step();
    co_ready = 1'b0; co_rd = '0;
    chk("t2_ready", 32'(req_ready), 32'd2);
    chk("t2_wr",    32'(req_wr),    32'd0);
    chk("t2_rd",    req_rd,         32'h5555_AAAA);
    step();
    chk("t2_grant_idle", 32'(grant), 32'd0);

    // Asynchronous reset in the middle of a BUSY cycle.
    req_valid = 2'b10;
    step();
    chk("t3_grant_pre", 32'(grant), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t3_co_valid", 32'(co_valid),  32'd0);
    chk("t3_grant",    32'(grant),     32'd0);
    chk("t3_busy",     32'(busy),      32'd0);
    chk("t3_ready",    32'(req_ready), 32'd0);
    req_valid = 2'b00;
    step();
    chk("t3_ready_held", 32'(req_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Both requesters continuously valid: grants alternate starting at requester 0.
    req_insn = {32'hB000_0001, 32'hA000_0000};
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("cont_grant", 32'(grant), 32'(exp_g[t]));
      chk("cont_insn",  co_insn, (exp_g[t] == 2'b01) ? 32'hA000_0000 : 32'hB000_0001);
      exp_rd = 32'h100 + 32'(t);
      co_ready = 1'b1; co_wr = 1'(t); co_rd = exp_rd;
      step();
      co_ready = 1'b0; co_wr = 1'b0; co_rd = '0;
      chk("cont_ready", 32'(req_ready), 32'(exp_g[t]));
      chk("cont_rd",    req_rd,         exp_rd);
      chk("cont_wr",    32'(req_wr),    32'(t % 2));
      chk("cont_err",   32'(req_err),   32'd0);
      step();
      chk("cont_idle_grant", 32'(grant), 32'd0);
    end
    req_valid = 2'b00;
    step();

`ifdef PCPI_ARB_TIMEOUT_EN
    // Watchdog expiry with co_wait low: response in the 17th cycle after grant.
    req_valid = 2'b01;
    req_insn[31:0] = 32'h0000_0077;
    step();
    chk("to_grant", 32'(grant), 32'd1);
    req_valid = 2'b00;
    seen = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step();
      if (req_ready != 2'b00) seen = 1'b1;
    end
    chk("to_no_early", 32'(seen), 32'd0);
    step();
    chk("to_ready", 32'(req_ready), 32'd1);
    chk("to_err",   32'(req_err),   32'd1);
    chk("to_wr",    32'(req_wr),    32'd0);
    chk("to_rd",    req_rd,         32'd0);
    step();
    chk("to_idle", 32'(busy), 32'd0);

    // co_wait held high keeps the watchdog cleared.
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    co_wait = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (req_ready != 2'b00) seen = 1'b1;
    end
    chk("wait_no_timeout", 32'(seen),     32'd0);
    chk("wait_still_busy", 32'(co_valid), 32'd1);
    co_wait = 1'b0; co_ready = 1'b1; co_wr = 1'b1; co_rd = 32'h0BAD_F00D;
    step();
    co_ready = 1'b0; co_wr = 1'b0; co_rd = '0;
    chk("wait_ready", 32'(req_ready), 32'd1);
    chk("wait_err",   32'(req_err),   32'd0);
    chk("wait_rd",    req_rd,         32'h0BAD_F00D);
    step();

    // co_ready coincides with the expiring cycle: normal response wins.
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    for (int c = 2; c <= 16; c++) step();
    co_ready = 1'b1; co_wr = 1'b1; co_rd = 32'h0000_C0DE;
    step();
    co_ready = 1'b0; co_wr = 1'b0; co_rd = '0;
    chk("coin_ready", 32'(req_ready), 32'd1);
    chk("coin_err",   32'(req_err),   32'd0);
    chk("coin_rd",    req_rd,         32'h0000_C0DE);
    chk("coin_wr",    32'(req_wr),    32'd1);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
